sha_mem_arbiter: RTL and testbench
==================================

# sha_mem_arbiter

Round-robin arbiter that shares one word-addressed message/hash memory port between `NUM_ENGINES` SHA-256 engines. Each engine reads its 16-word message blocks and writes its 8-word digest through this block. The arbiter grants ownership of the port for a burst, muxes the owner's address/data/write-enable onto the memory, and routes returned read data back with a per-engine valid strobe. It sits between the engine array and the single memory instance, and also drives `mem_clk`.

## Interface
- `NUM_ENGINES`, 4, number of requesting engines (2..8)
- `ADDR_W`, 16, memory word-address width
- `DATA_W`, 32, memory data width
- `MAX_HOLD`, 64, cycles an owner may hold the port before it can be preempted
- `clk`  in  1  single clock; also drives `mem_clk`
- `reset`  in  1  synchronous, active-high reset
- `req`  in  NUM_ENGINES  per-engine port request; held high for the whole burst
- `eng_we`  in  NUM_ENGINES  per-engine write enable for the current access
- `eng_addr`  in  NUM_ENGINES*ADDR_W  per-engine address; engine i occupies slice i
- `eng_wdata`  in  NUM_ENGINES*DATA_W  per-engine write data
- `gnt`  out  NUM_ENGINES  one-hot ownership, registered
- `rvalid`  out  NUM_ENGINES  read data valid for engine i
- `rdata`  out  DATA_W  `mem_read_data`, broadcast to all engines
- `busy`  out  1  high whenever the state is not IDLE
- `mem_clk`  out  1  equal to `clk`
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_write_data`  out  DATA_W  memory write data
- `mem_read_data`  in  DATA_W  memory read data, valid one cycle after the address

## Operation
- **States:** IDLE, OWN, RELEASE.
- **IDLE:**
  - `gnt` is 0.
  - If any `req` is high, register the round-robin winner into `gnt`, clear `hold_cnt`, and go to OWN.
- **Round-robin:** search begins at index (last_owner+1) mod N. `last_owner` resets to N-1, so engine 0 has priority after reset.
- **OWN:**
  - An access occurs in every cycle where `gnt[i] & req[i]`.
  - `mem_we = gnt[i] & req[i] & eng_we[i]`; `mem_addr` and `mem_write_data` come from the owner's slices.
  - `hold_cnt` increments each cycle and saturates at MAX_HOLD-1.
- **Leaving OWN:** go to RELEASE when the owner drops `req`, or when `hold_cnt == MAX_HOLD-1` and another engine is requesting (preemption).
  - On leaving, clear `gnt` and set `last_owner` to the owner's index.
- **RELEASE:**
  - One dead cycle: `gnt` = 0 and `mem_we` = 0.
  - If any `req` is high, grant the next winner and go to OWN; otherwise go to IDLE.
- **Read return:** `rvalid[i]` is registered. It is high in cycle t+1 for every cycle t with `gnt[i] & req[i] & !eng_we[i]`. This includes a read issued in the last OWN cycle, whose `rvalid` lands in RELEASE.
- **Preempted engine:** keeps `req` high and stalls. It is re-granted after every other requester has been served once.
- **Ungranted port:** when no engine is granted, `mem_we` = 0, `mem_addr` = 0 and `mem_write_data` = 0.
- **Reset:** applies on the edge where `reset` is sampled high, including mid-burst. State goes to IDLE and `hold_cnt` to 0.
  - An in-flight read's `rvalid` is suppressed.

## Timing
- **Reset values:** `gnt`=0, `rvalid`=0, `busy`=0, `mem_we`=0, `mem_addr`=0, `mem_write_data`=0.
- **Grant latency:** `req` rising at cycle t with the port idle gives `gnt` at t+1.
- **Handover:** exactly one dead cycle between owners. `req` dropped at cycle t gives RELEASE at t+1 and the next owner's `gnt` at t+2.
- **Read latency:** 1 cycle from address to `rvalid`/`rdata`.
- **Mux path:** the memory-side outputs are combinational from registered `gnt` and the owner's inputs. There is no added latency on writes.
- **Simultaneous events:**
  - Requests arriving in the same cycle are resolved by the round-robin pointer.
  - A `req` drop coinciding with preemption is treated as a normal release.

## Structure
- **Package `sha_arb_pkg`:** state enum (IDLE, OWN, RELEASE) and default widths ADDR_W=16, DATA_W=32.
- **Sub-module `rr_pick`:** combinational; inputs `req` and `last_owner`, outputs a one-hot winner and its index. Reused by future engine schedulers.

## Test plan
- **Single burst:** engine 1 alone requests and reads addresses 0x0000..0x000F.
  - `gnt`=0b0010 one cycle after `req`; 16 `rvalid[1]` pulses, each one cycle after its address.
  - `rdata` matches the memory image.
- **Round-robin handover:** all 4 engines request at once after reset.
  - Grant order 0,1,2,3, with one `gnt`=0 cycle between owners.
  - Engine 0 re-requesting after its release is served after engine 3.
- **Preemption:** engine 0 holds `req` for 200 cycles while engine 2 requests at cycle 10.
  - Engine 0 loses `gnt` after 64 OWN cycles; engine 2 is granted 1 cycle later.
  - Engine 0 is re-granted when engine 2 releases.
- **No preemption when alone:** engine 3 holds `req` for 100 cycles with no competitor.
  - `gnt`=0b1000 continuously; `hold_cnt` saturates at 63.
- **Write path:** engine 2 writes 8 digest words to 0x0100..0x0107.
  - `mem_we` is high for exactly 8 cycles; memory holds the data; no `rvalid` pulses.
- **Reset mid-burst:** assert `reset` during engine 1's read burst.
  - Next cycle: all outputs are 0 and `busy`=0.
  - After reset, with engines 1 and 0 requesting, engine 0 is granted first.

Source files
------------

// File: rtl/sha_arb_pkg.sv
// Shared types for the SHA engine memory arbiter: FSM state encoding and default port widths.
package sha_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches from last_owner+1 upward (wrapping), zero latency.
// Returns an all-zero winner when nothing requests; no flow control of its own.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_owner,
  output logic [N-1:0]     winner,
  output logic [IDX_W-1:0] winner_idx
);

  logic [IDX_W-1:0] idx;

  // Walk from the furthest candidate back to the nearest so the nearest match wins.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    idx        = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IDX_W'((int'(last_owner) + k) % N);
      if (req[idx]) begin
        winner      = '0;
        winner[idx] = 1'b1;
        winner_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/sha_mem_arbiter.sv
// Round-robin owner arbitration of one memory port across SHA engines; 1-cycle grant, 1-cycle read return.
// Non-owners stall with req held; owner is preempted after MAX_HOLD cycles only if someone else waits.
module sha_mem_arbiter
  import sha_arb_pkg::*;
#(
  parameter int NUM_ENGINES = 4,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MAX_HOLD    = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_ENGINES-1:0]        req,
  input  logic [NUM_ENGINES-1:0]        eng_we,
  input  logic [NUM_ENGINES*ADDR_W-1:0] eng_addr,
  input  logic [NUM_ENGINES*DATA_W-1:0] eng_wdata,
  output logic [NUM_ENGINES-1:0]        gnt,
  output logic [NUM_ENGINES-1:0]        rvalid,
  output logic [DATA_W-1:0]             rdata,
  output logic                          busy,
  output logic                          mem_clk,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_write_data,
  input  logic [DATA_W-1:0]             mem_read_data
);

  localparam int IDX_W  = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_t             state;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [IDX_W-1:0]       last_owner;
  logic [IDX_W-1:0]       owner_idx;
  logic [NUM_ENGINES-1:0] pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   owner_req;
  logic                   others_req;

  rr_pick #(
    .N     (NUM_ENGINES),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req        (req),
    .last_owner (last_owner),
    .winner     (pick_gnt),
    .winner_idx (pick_idx)
  );

  assign owner_req  = |(gnt & req);
  assign others_req = |(req & ~gnt);
  assign busy       = (state != IDLE);
  assign mem_clk    = clk;
  assign rdata      = mem_read_data;
  assign mem_we     = |(gnt & req & eng_we);

  // gnt is zero outside OWN, so the mux naturally parks the port at all-zero.
  always_comb begin
    mem_addr       = '0;
    mem_write_data = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (gnt[i]) begin
        mem_addr       = eng_addr[i*ADDR_W +: ADDR_W];
        mem_write_data = eng_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= '0;
      rvalid     <= '0;
      hold_cnt   <= '0;
      owner_idx  <= '0;
      last_owner <= IDX_W'(NUM_ENGINES - 1);
    end else begin
      rvalid <= gnt & req & ~eng_we;
      case (state)
        IDLE, RELEASE: begin
          if (|req) begin
            gnt       <= pick_gnt;
            owner_idx <= pick_idx;
            hold_cnt  <= '0;
            state     <= OWN;
          end else begin
            state <= IDLE;
          end
        end
        OWN: begin
          // A req drop takes priority; preemption only matters while the owner still wants the port.
          if (!owner_req || (hold_cnt == HOLD_LAST && others_req)) begin
            gnt        <= '0;
            last_owner <= owner_idx;
            state      <= RELEASE;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha_mem_arbiter.sv
// Directed bench for sha_mem_arbiter with a behavioural word memory and hand-derived expectations.
module tb_sha_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [N-1:0]      eng_we;
  logic [N*AW-1:0]   eng_addr;
  logic [N*DW-1:0]   eng_wdata;
  logic [N-1:0]      gnt;
  logic [N-1:0]      rvalid;
  logic [DW-1:0]     rdata;
  logic              busy;
  logic              mem_clk;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_write_data;
  logic [DW-1:0]     mem_read_data;

  sha_mem_arbiter #(
    .NUM_ENGINES (N),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .MAX_HOLD    (64)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .eng_we         (eng_we),
    .eng_addr       (eng_addr),
    .eng_wdata      (eng_wdata),
    .gnt            (gnt),
    .rvalid         (rvalid),
    .rdata          (rdata),
    .busy           (busy),
    .mem_clk        (mem_clk),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] img(input logic [AW-1:0] a);
    return 32'h9E37_0000 ^ (32'(a) * 32'h0101_0101);
  endfunction

  function automatic logic [DW-1:0] dig(input int k);
    return 32'hD160_0000 + 32'(k);
  endfunction

  // Read-only image below 0x100, writable page at 0x100..0x1FF.
  logic [DW-1:0] wmem [0:255];
  always @(posedge mem_clk) begin
    if (mem_we && mem_addr[15:8] == 8'h01) wmem[mem_addr[7:0]] <= mem_write_data;
    mem_read_data <= (mem_addr[15:8] == 8'h01) ? wmem[mem_addr[7:0]] : img(mem_addr);
  end

  int rv_cnt [N];
  int we_cnt;
  initial begin
    for (int i = 0; i < N; i++) rv_cnt[i] = 0;
    we_cnt = 0;
  end
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) rv_cnt[i] <= rv_cnt[i] + int'(rvalid[i]);
    we_cnt <= we_cnt + int'(mem_we);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] v);
    eng_addr[i*AW +: AW] = v;
  endtask

  task automatic set_wdata(input int i, input logic [DW-1:0] v);
    eng_wdata[i*DW +: DW] = v;
  endtask

  int n;
  int cnt;
  int rv_before;
  int we_before;
  int order [5] = '{0, 1, 2, 3, 0};
  logic [N-1:0] reqv;

  initial begin
    reset     = 1'b1;
    req       = '1;
    eng_we    = '0;
    eng_addr  = {16'h3333, 16'h2222, 16'h1111, 16'h0AAA};
    eng_wdata = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    tick();
    tick();
    // Reset state with every engine requesting and nonzero engine buses.
    check("rst_gnt",    gnt, 4'b0000);
    check("rst_rvalid", rvalid, 4'b0000);
    check("rst_busy",   busy, 1'b0);
    check("rst_we",     mem_we, 1'b0);
    check("rst_addr",   mem_addr, 16'h0000);
    check("rst_wdata",  mem_write_data, 32'h0);
    req       = '0;
    eng_addr  = '0;
    eng_wdata = '0;
    tick();
    reset = 1'b0;
    tick();

    // Single read burst from engine 1.
    req[1] = 1'b1;
    tick();
    check("burst_gnt",  gnt, 4'b0010);
    check("burst_busy", busy, 1'b1);
    for (int k = 0; k < 16; k++) begin
      set_addr(1, AW'(k));
      #1;
      check("burst_addr", mem_addr, 64'(k));
      check("burst_we",   mem_we, 1'b0);
      tick();
      check("burst_rvalid", rvalid, 4'b0010);
      check("burst_rdata",  rdata, img(AW'(k)));
    end
    req[1] = 1'b0;
    tick();
    check("burst_release_gnt",    gnt, 4'b0000);
    check("burst_release_rvalid", rvalid, 4'b0000);
    check("burst_release_busy",   busy, 1'b1);
    tick();
    check("burst_idle_busy", busy, 1'b0);
    check("burst_rv_count",  rv_cnt[1], 16);

    // Round-robin handover with engine 0 re-requesting after its first release.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    reqv  = 4'b1111;
    req   = reqv;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("rr_gnt", gnt, 64'(1) << order[i]);
      tick();
      check("rr_hold", gnt, 64'(1) << order[i]);
      reqv[order[i]] = 1'b0;
      req = reqv;
      tick();
      check("rr_dead", gnt, 4'b0000);
      if (i == 0) begin
        reqv[0] = 1'b1;
        req     = reqv;
      end
      tick();
    end
    check("rr_idle_busy", busy, 1'b0);

    // Preemption: engine 0 streams reads, engine 2 arrives later.
    req = 4'b0001;
    set_addr(0, 16'h0007);
    tick();
    n = 0;
    while (gnt == 4'b0001 && n < 200) begin
      n++;
      if (n == 9) req[2] = 1'b1;
      tick();
    end
    check("pre_own_cycles",    n, 64);
    check("pre_release_gnt",   gnt, 4'b0000);
    check("pre_last_rvalid",   rvalid, 4'b0001);
    check("pre_last_rdata",    rdata, img(16'h0007));
    tick();
    check("pre_new_owner",     gnt, 4'b0100);
    tick();
    tick();
    req[2] = 1'b0;
    tick();
    check("pre_dead",          gnt, 4'b0000);
    tick();
    check("pre_regrant",       gnt, 4'b0001);
    req = '0;
    tick();
    tick();

    // Lone owner is never preempted; hold counter saturates.
    req = 4'b1000;
    tick();
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (gnt == 4'b1000) cnt++;
      tick();
    end
    check("alone_gnt_cycles", cnt, 100);
    check("alone_gnt_now",    gnt, 4'b1000);
    check("alone_hold_sat",   dut.hold_cnt, 63);
    req = '0;
    tick();
    tick();

    // Digest write path from engine 2.
    rv_before = rv_cnt[0] + rv_cnt[1] + rv_cnt[2] + rv_cnt[3];
    we_before = we_cnt;
    req       = 4'b0100;
    eng_we    = 4'b0100;
    set_addr(2, 16'h0100);
    set_wdata(2, dig(0));
    tick();
    check("wr_gnt", gnt, 4'b0100);
    for (int k = 0; k < 8; k++) begin
      set_addr(2, 16'h0100 + AW'(k));
      set_wdata(2, dig(k));
      #1;
      check("wr_we",    mem_we, 1'b1);
      check("wr_addr",  mem_addr, 64'(16'h0100 + k));
      check("wr_wdata", mem_write_data, dig(k));
      tick();
    end
    req    = '0;
    eng_we = '0;
    tick();
    tick();
    check("wr_we_count", we_cnt - we_before, 8);
    check("wr_no_rvalid", rv_cnt[0] + rv_cnt[1] + rv_cnt[2] + rv_cnt[3] - rv_before, 0);
    for (int k = 0; k < 8; k++) check("wr_mem", wmem[k], dig(k));

    // Reset mid-burst after engine 0 has been the most recent owner.
    req = 4'b0001;
    tick();
    tick();
    req = '0;
    tick();
    tick();
    req = 4'b0010;
    set_addr(1, 16'h0005);
    set_wdata(1, 32'hFFFF_0001);
    tick();
    check("mid_gnt", gnt, 4'b0010);
    tick();
    tick();
    reset = 1'b1;
    req   = 4'b0011;
    tick();
    check("mid_rst_gnt",    gnt, 4'b0000);
    check("mid_rst_rvalid", rvalid, 4'b0000);
    check("mid_rst_busy",   busy, 1'b0);
    check("mid_rst_we",     mem_we, 1'b0);
    check("mid_rst_addr",   mem_addr, 16'h0000);
    check("mid_rst_wdata",  mem_write_data, 32'h0);
    reset = 1'b0;
    tick();
    check("mid_post_gnt", gnt, 4'b0001);
    req = '0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
